// File: rtl/neuron_mode_ctrl_if.sv
// rtl/neuron_mode_ctrl_if.sv - mode-change request handshake between host/config and neuron_mode_ctrl
interface neuron_mode_ctrl_if;
   logic       mode_req_valid;
   logic [1:0] mode_req;
   logic       mode_req_ready;

   modport master (output mode_req_valid, output mode_req, input mode_req_ready);
   modport slave  (input mode_req_valid, input mode_req, output mode_req_ready);
endinterface

// File: rtl/neuron_mode_ctrl.sv
// rtl/neuron_mode_ctrl.sv - quiesce/clear/settle sequencer for the neuron engine-select mux
// Optional DRAIN timeout enabled by defining NEURON_MODE_CTRL_TIMEOUT_EN.
module neuron_mode_ctrl #(
   parameter int SETTLE_CYCLES = 4,
   parameter int DRAIN_TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   neuron_mode_ctrl_if.slave   req_if,
   input  logic [3:0]          engine_busy,
   output logic [1:0]          mode,
   output logic [3:0]          engine_enable,
   output logic [3:0]          engine_clear,
   output logic                switching,
   output logic                switch_done,
   output logic                timeout_flag
);

   typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, SETTLE} state_t;

   state_t     state, state_nxt;
   logic [1:0] target, target_nxt;
   logic [1:0] mode_nxt;
   logic [3:0] enable_nxt, clear_nxt;
   logic       switching_nxt, done_nxt, tflag_nxt;
   logic [3:0] settle_cnt, settle_nxt;
   logic       accept, go_clear, finish;

   function automatic logic [3:0] onehot(input logic [1:0] m);
      return 4'b0001 << m;
   endfunction

   assign req_if.mode_req_ready = (state == IDLE);
   assign accept = req_if.mode_req_valid && (state == IDLE);

`ifdef NEURON_MODE_CTRL_TIMEOUT_EN
   localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TIMEOUT - 1);
   logic [7:0] drain_cnt, drain_nxt;
`else
   logic [7:0] unused_drain_timeout;
   assign unused_drain_timeout = 8'(DRAIN_TIMEOUT);
`endif

   always_comb begin
      state_nxt     = state;
      target_nxt    = target;
      mode_nxt      = mode;
      enable_nxt    = engine_enable;
      clear_nxt     = 4'b0000;
      switching_nxt = switching;
      done_nxt      = 1'b0;
      tflag_nxt     = timeout_flag;
      settle_nxt    = settle_cnt;
      go_clear      = 1'b0;
      finish        = 1'b0;
`ifdef NEURON_MODE_CTRL_TIMEOUT_EN
      drain_nxt     = drain_cnt;
`endif
      case (state)
         IDLE: begin
            if (accept) begin
               tflag_nxt = 1'b0;
               if (req_if.mode_req != mode) begin
                  target_nxt    = req_if.mode_req;
                  enable_nxt    = 4'b0000;
                  switching_nxt = 1'b1;
                  state_nxt     = DRAIN;
`ifdef NEURON_MODE_CTRL_TIMEOUT_EN
                  drain_nxt     = 8'd0;
`endif
               end
            end
         end
         DRAIN: begin
            // mode still holds the outgoing engine here; busy low beats the timeout
            if (!engine_busy[mode]) begin
               go_clear = 1'b1;
            end else begin
`ifdef NEURON_MODE_CTRL_TIMEOUT_EN
               if (drain_cnt == DRAIN_LAST) begin
                  tflag_nxt = 1'b1;
                  go_clear  = 1'b1;
               end else begin
                  drain_nxt = drain_cnt + 8'd1;
               end
`endif
            end
            if (go_clear) begin
               state_nxt = CLEAR;
               mode_nxt  = target;
               clear_nxt = onehot(target);
            end
         end
         CLEAR: begin
            if (SETTLE_CYCLES > 0) begin
               state_nxt  = SETTLE;
               settle_nxt = 4'(SETTLE_CYCLES);
            end else begin
               finish = 1'b1;
            end
         end
         SETTLE: begin
            if (settle_cnt <= 4'd1) finish = 1'b1;
            else                    settle_nxt = settle_cnt - 4'd1;
         end
         default: state_nxt = IDLE;
      endcase
      if (finish) begin
         state_nxt     = IDLE;
         enable_nxt    = onehot(mode);
         switching_nxt = 1'b0;
         done_nxt      = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         target        <= 2'd0;
         mode          <= 2'd0;
         engine_enable <= 4'b0001;
         engine_clear  <= 4'b0000;
         switching     <= 1'b0;
         switch_done   <= 1'b0;
         settle_cnt    <= 4'd0;
      end else begin
         state         <= state_nxt;
         target        <= target_nxt;
         mode          <= mode_nxt;
         engine_enable <= enable_nxt;
         engine_clear  <= clear_nxt;
         switching     <= switching_nxt;
         switch_done   <= done_nxt;
         settle_cnt    <= settle_nxt;
      end
   end

`ifdef NEURON_MODE_CTRL_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drain_cnt    <= 8'd0;
         timeout_flag <= 1'b0;
      end else begin
         drain_cnt    <= drain_nxt;
         timeout_flag <= tflag_nxt;
      end
   end
`else
   logic unused_tflag;
   assign unused_tflag = tflag_nxt;
   assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_neuron_mode_ctrl.sv
// tb/tb_neuron_mode_ctrl.sv - directed self-checking bench for neuron_mode_ctrl
module tb_neuron_mode_ctrl;
`ifdef NEURON_MODE_CTRL_TIMEOUT_EN
   localparam int DT = 16;
`else
   localparam int DT = 255;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] engine_busy;
   logic [1:0] mode;
   logic [3:0] engine_enable, engine_clear;
   logic       switching, switch_done, timeout_flag;
   int         vectors = 0;
   int         miscompares = 0;

   neuron_mode_ctrl_if req_if ();

   neuron_mode_ctrl #(.SETTLE_CYCLES(4), .DRAIN_TIMEOUT(DT)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_if        (req_if.slave),
      .engine_busy   (engine_busy),
      .mode          (mode),
      .engine_enable (engine_enable),
      .engine_clear  (engine_clear),
      .switching     (switching),
      .switch_done   (switch_done),
      .timeout_flag  (timeout_flag)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag, input logic [1:0] m);
      chk({tag, "_mode"}, 32'(mode), 32'(m));
      chk({tag, "_en"}, 32'(engine_enable), 32'(4'b0001 << m));
      chk({tag, "_rdy"}, 32'(req_if.mode_req_ready), 32'd1);
      chk({tag, "_pulses"}, 32'({engine_clear, switching, switch_done}), 32'd0);
   endtask

   // presents a request with busy held low; returns cycles from acceptance to switch_done
   task automatic switch_to(input logic [1:0] m, input int lat);
      int n;
      req_if.mode_req_valid = 1'b1;
      req_if.mode_req       = m;
      tick();
      req_if.mode_req_valid = 1'b0;
      n = 1;
      while (!switch_done && n < 2000) begin
         tick();
         n++;
      end
      chk("switch_lat", 32'(n), 32'(lat));
      chk("switch_mode", 32'(mode), 32'(m));
   endtask

   initial begin
      int held;
      rst_n                 = 1'b0;
      engine_busy           = 4'b0000;
      req_if.mode_req_valid = 1'b0;
      req_if.mode_req       = 2'd0;
      repeat (2) @(negedge clk);
      chk_idle("in_reset", 2'd0);
      chk("in_reset_tflag", 32'(timeout_flag), 32'd0);
      rst_n = 1'b1;
      tick();
      chk_idle("reset", 2'd0);

      // clean switch LIF -> TD
      req_if.mode_req_valid = 1'b1;
      req_if.mode_req       = 2'd1;
      tick();
      req_if.mode_req_valid = 1'b0;
      chk("c1_en", 32'(engine_enable), 32'h0);
      chk("c1_sw", 32'(switching), 32'd1);
      chk("c1_rdy", 32'(req_if.mode_req_ready), 32'd0);
      chk("c1_mode", 32'(mode), 32'd0);
      tick();
      chk("c2_mode", 32'(mode), 32'd1);
      chk("c2_clear", 32'(engine_clear), 32'h2);
      chk("c2_en", 32'(engine_enable), 32'h0);
      for (int c = 3; c <= 6; c++) begin
         tick();
         chk("settle_state", 32'({engine_enable, engine_clear, switching, switch_done}), 32'h002);
      end
      tick();
      chk("c7_done", 32'(switch_done), 32'd1);
      chk("c7_en", 32'(engine_enable), 32'h2);
      chk("c7_sw", 32'(switching), 32'd0);
      chk("c7_rdy", 32'(req_if.mode_req_ready), 32'd1);
      tick();
      chk("c8_done", 32'(switch_done), 32'd0);

      // no-op request to the current mode
      req_if.mode_req_valid = 1'b1;
      req_if.mode_req       = 2'd1;
      tick();
      req_if.mode_req_valid = 1'b0;
      chk_idle("noop1", 2'd1);
      tick();
      chk_idle("noop2", 2'd1);

      // drain wait: LIF busy for 10 cycles, inactive CONV busy bit must be ignored
      switch_to(2'd0, 7);
      tick();
      engine_busy           = 4'b1001;
      req_if.mode_req_valid = 1'b1;
      req_if.mode_req       = 2'd3;
      tick();
      req_if.mode_req_valid = 1'b0;
      for (int c = 2; c <= 11; c++) tick();
      chk("drain_c11_clear", 32'(engine_clear), 32'h0);
      chk("drain_c11_sw", 32'(switching), 32'd1);
      engine_busy = 4'b0000;
      tick();
      chk("drain_c12_clear", 32'(engine_clear), 32'h8);
      chk("drain_c12_mode", 32'(mode), 32'd3);
      repeat (5) tick();
      chk("drain_done", 32'(switch_done), 32'd1);
      chk("drain_tflag", 32'(timeout_flag), 32'd0);

      // back-to-back: accept FST in the cycle switch_done of the LIF switch is high
      switch_to(2'd0, 7);
      chk("b2b_rdy", 32'(req_if.mode_req_ready), 32'd1);
      engine_busy           = 4'b0001;
      req_if.mode_req_valid = 1'b1;
      req_if.mode_req       = 2'd2;
      tick();
      req_if.mode_req_valid = 1'b0;
      chk("b2b_sw", 32'(switching), 32'd1);
`ifdef NEURON_MODE_CTRL_TIMEOUT_EN
      for (int c = 2; c <= 16; c++) tick();
      chk("to_c16_clear", 32'(engine_clear), 32'h0);
      chk("to_c16_tflag", 32'(timeout_flag), 32'd0);
      tick();
      chk("to_c17_clear", 32'(engine_clear), 32'h4);
      chk("to_c17_tflag", 32'(timeout_flag), 32'd1);
      repeat (5) tick();
      chk("to_done", 32'(switch_done), 32'd1);
      chk("to_tflag_sticky", 32'(timeout_flag), 32'd1);
      req_if.mode_req_valid = 1'b1;
      req_if.mode_req       = 2'd2;
      tick();
      req_if.mode_req_valid = 1'b0;
      chk("to_tflag_clr", 32'(timeout_flag), 32'd0);
      chk_idle("to_noop", 2'd2);
      engine_busy = 4'b0000;
`else
      held = 0;
      for (int c = 0; c < 1000; c++) begin
         if (switching && engine_clear == 4'h0 && mode == 2'd0) held++;
         tick();
      end
      chk("drain_hold", 32'(held), 32'd1000);
      engine_busy = 4'b0000;
      tick();
      chk("hold_clear", 32'(engine_clear), 32'h4);
      chk("hold_tflag", 32'(timeout_flag), 32'd0);
      repeat (5) tick();
      chk("hold_done", 32'(switch_done), 32'd1);
`endif

      // reset during SETTLE
      tick();
      req_if.mode_req_valid = 1'b1;
      req_if.mode_req       = 2'd1;
      tick();
      req_if.mode_req_valid = 1'b0;
      tick();
      tick();
      chk("rst_pre_sw", 32'(switching), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_idle("rst_async", 2'd0);
      chk("rst_async_tflag", 32'(timeout_flag), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      held = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (switch_done) held++;
      end
      chk("rst_no_done", 32'(held), 32'd0);
      chk_idle("rst_after", 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/neuron_mode_ctrl.md
# neuron_mode_ctrl

Sequences mode changes for the neuron core's engine-select path. Accepts a mode-change request and quiesces the active engine (LIF, TD, FST or CONV). It then drives the shared `mode` select, clears the incoming engine and re-enables it after a settle window. The block sits between the host/config register interface and the mode-select mux plus the four engines, so the mux never switches while an engine still has a spike, emit or learn transaction in flight.

## Interface
Parameters:
- `SETTLE_CYCLES`, 4: idle cycles between clearing the new engine and enabling it (0..15).
- `DRAIN_TIMEOUT`, 255: maximum busy-high cycles spent in DRAIN before a forced switch (1..255; 8-bit counter).

Ports:
- `clk`  in  1  core clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode_req_valid`  in  1  a mode-change request is presented.
- `mode_req`  in  2  requested mode: LIF=2'd0, TD=2'd1, FST=2'd2, CONV=2'd3.
- `mode_req_ready`  out  1  high only in IDLE; a request is accepted when valid && ready.
- `engine_busy`  in  4  per-engine busy; bit index equals mode code.
- `mode`  out  2  registered select to the mode-select mux.
- `engine_enable`  out  4  one-hot enable; bit `mode` is high only in IDLE.
- `engine_clear`  out  4  one-cycle state-clear pulse to the incoming engine.
- `switching`  out  1  high in DRAIN, CLEAR and SETTLE.
- `switch_done`  out  1  one-cycle pulse in the first IDLE cycle after a switch.
- `timeout_flag`  out  1  sticky; set by a forced switch; cleared when the next request is accepted.

## Operation
- **Reset values:**
  - `mode`=2'd0 (LIF).
  - `engine_enable`=4'b0001.
  - `engine_clear`=0, `switching`=0, `switch_done`=0, `timeout_flag`=0.
  - State IDLE, target register 0, counters 0.
- **IDLE:**
  - `mode_req_ready`=1.
  - On acceptance with `mode_req`==`mode`: no-op. State stays IDLE, no pulses, `timeout_flag` is cleared.
  - On acceptance with a different mode: latch the target, clear `timeout_flag`, drop `engine_enable` to 0, then go to DRAIN.
- **DRAIN:**
  - Each cycle, sample `engine_busy[mode]`, where `mode` is still the old value.
  - If it is low, go to CLEAR.
  - If it is high, increment the drain counter.
  - When the counter reaches `DRAIN_TIMEOUT`, set `timeout_flag` and go to CLEAR.
- **CLEAR** (exactly one cycle):
  - `mode` = target, registered on entry.
  - `engine_clear[target]`=1 for this cycle only.
  - Next state is SETTLE if `SETTLE_CYCLES`>0, otherwise IDLE.
- **SETTLE:**
  - Down-counter loaded with `SETTLE_CYCLES`; go to IDLE after that many cycles.
  - `engine_busy` is ignored.
- **Entering IDLE from CLEAR or SETTLE:** `engine_enable`=one-hot(`mode`) and `switch_done`=1 for one cycle.
- **Requests outside IDLE:** not accepted, since ready is low. The requester holds valid per standard valid/ready rules.
- **Unused inputs:** busy bits of non-active engines are ignored in all states.
- **Reset mid-switch:** an asynchronous return to reset values. The pending target is discarded and no `switch_done` is produced.

## Timing
- All outputs are registered; none depends combinationally on an input, except `mode_req_ready`, which is decoded from state only.
- **Minimum switch latency:** request accepted at edge 0 → DRAIN in cycle 1 (busy low) → CLEAR in cycle 2 → SETTLE in cycles 3..2+`SETTLE_CYCLES` → IDLE with `switch_done` in cycle 3+`SETTLE_CYCLES`. With the default of 4, that is cycle 7.
- With `SETTLE_CYCLES`=0, `switch_done` occurs in cycle 3.
- **Drain with busy high:** DRAIN lasts (busy-high cycles + 1) cycles, capped at `DRAIN_TIMEOUT` cycles.
- **Enable coverage:** `engine_enable` is all-zero from cycle 1 through the last SETTLE cycle inclusive.
- **Busy falling on the timeout cycle:** busy low takes priority; `timeout_flag` is not set.
- **Back-to-back requests:** a new request can be accepted in the same cycle that `switch_done` is high.

## Configuration
- `NEURON_MODE_CTRL_TIMEOUT_EN` defined: DRAIN timeout as specified; `timeout_flag` functional.
- `NEURON_MODE_CTRL_TIMEOUT_EN` undefined:
  - DRAIN waits indefinitely for busy low, and the drain counter is removed.
  - `timeout_flag` is tied to 0.
  - `DRAIN_TIMEOUT` is ignored.

## Test plan
- **Reset:** reset released → `mode`=0, `engine_enable`=4'b0001, `mode_req_ready`=1, all pulses 0.
- **Clean switch:** request TD (1), busy all 0, default parameters → `engine_enable`=0 in cycles 1-6, `engine_clear`=4'b0010 in cycle 2, `mode`=1 from cycle 2, `switch_done` and `engine_enable`=4'b0010 in cycle 7.
- **Drain wait:** from LIF, request CONV (3) while `engine_busy[0]` is high for 10 cycles → CLEAR occurs 11 cycles after entering DRAIN; `timeout_flag` stays 0; `engine_clear`=4'b1000.
- **Forced switch:** with the macro defined and `DRAIN_TIMEOUT`=16, `engine_busy[0]` stuck high, request FST → CLEAR after 16 DRAIN cycles and `timeout_flag`=1. The next accepted request (same mode) clears it. With the macro undefined, the bench observes DRAIN held for 1000 cycles.
- **No-op request:** request `mode_req`=current mode → no state change, no `engine_clear`, no `switch_done`, `mode_req_ready` stays 1.
- **Reset mid-switch:** assert `rst_n` low during SETTLE → outputs return to reset values asynchronously; after release, `mode`=0 and no `switch_done` is seen.
